// File: rtl/fft32.sv
// 32-point radix-2 DIT FFT on packed 8-bit complex samples.
// Input and output registered around a fully combinational butterfly network.
module fft32 (
    input  logic         clk1,
    input  logic         rst,
    input  logic [255:0] Xn_vect_real,
    input  logic [255:0] Xn_vect_imag,
    output logic [255:0] Xk_vect_real,
    output logic [255:0] Xk_vect_imag
);

    logic [255:0]       xr_q;
    logic [255:0]       xi_q;
    logic [255:0]       yr;
    logic [255:0]       yi;

    logic signed [15:0] sr [0:5][0:31];
    logic signed [15:0] si [0:5][0:31];
    logic signed [26:0] pr;
    logic signed [26:0] pi;
    logic signed [15:0] br;
    logic signed [15:0] bi;
    logic signed [9:0]  wc;
    logic signed [9:0]  ws;
    logic [4:0]         lo;
    logic [4:0]         hi;
    logic [3:0]         m;

    function automatic logic [4:0] bitrev(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    // Q8 cos(2*pi*m/32)
    function automatic logic signed [9:0] tw_cos(input logic [3:0] idx);
        case (idx)
            4'd0:    return  10'sd256;
            4'd1:    return  10'sd251;
            4'd2:    return  10'sd237;
            4'd3:    return  10'sd213;
            4'd4:    return  10'sd181;
            4'd5:    return  10'sd142;
            4'd6:    return  10'sd98;
            4'd7:    return  10'sd50;
            4'd8:    return  10'sd0;
            4'd9:    return -10'sd50;
            4'd10:   return -10'sd98;
            4'd11:   return -10'sd142;
            4'd12:   return -10'sd181;
            4'd13:   return -10'sd213;
            4'd14:   return -10'sd237;
            default: return -10'sd251;
        endcase
    endfunction

    // Q8 -sin(2*pi*m/32)
    function automatic logic signed [9:0] tw_nsin(input logic [3:0] idx);
        case (idx)
            4'd0:    return  10'sd0;
            4'd1:    return -10'sd50;
            4'd2:    return -10'sd98;
            4'd3:    return -10'sd142;
            4'd4:    return -10'sd181;
            4'd5:    return -10'sd213;
            4'd6:    return -10'sd237;
            4'd7:    return -10'sd251;
            4'd8:    return -10'sd256;
            4'd9:    return -10'sd251;
            4'd10:   return -10'sd237;
            4'd11:   return -10'sd213;
            4'd12:   return -10'sd181;
            4'd13:   return -10'sd142;
            4'd14:   return -10'sd98;
            default: return -10'sd50;
        endcase
    endfunction

    always_comb begin
        sr = '{default: '{default: '0}};
        si = '{default: '{default: '0}};
        pr = '0;
        pi = '0;
        br = '0;
        bi = '0;
        wc = '0;
        ws = '0;
        lo = '0;
        hi = '0;
        m  = '0;
        yr = '0;
        yi = '0;

        for (int unsigned n = 0; n < 32; n++) begin
            sr[0][bitrev(5'(n))] = 16'(signed'(xr_q[8'(8 * n) +: 8]));
            si[0][bitrev(5'(n))] = 16'(signed'(xi_q[8'(8 * n) +: 8]));
        end

        // W^0 and W^8 have magnitude exactly 256, so the rounded product
        // reproduces the operand (or its -j rotation) bit-for-bit.
        for (int unsigned s = 0; s < 5; s++) begin
            for (int unsigned g = 0; g < 32; g += (2 << s)) begin
                for (int unsigned j = 0; j < (1 << s); j++) begin
                    lo = 5'(g + j);
                    hi = 5'(g + j + (1 << s));
                    m  = 4'(j << (4 - s));
                    wc = tw_cos(m);
                    ws = tw_nsin(m);
                    pr = 27'(sr[3'(s)][hi]) * 27'(wc) - 27'(si[3'(s)][hi]) * 27'(ws);
                    pi = 27'(sr[3'(s)][hi]) * 27'(ws) + 27'(si[3'(s)][hi]) * 27'(wc);
                    br = 16'((pr + 27'sd128) >>> 8);
                    bi = 16'((pi + 27'sd128) >>> 8);
                    sr[3'(s + 1)][hi] = sr[3'(s)][lo] - br;
                    si[3'(s + 1)][hi] = si[3'(s)][lo] - bi;
                    sr[3'(s + 1)][lo] = sr[3'(s)][lo] + br;
                    si[3'(s + 1)][lo] = si[3'(s)][lo] + bi;
                end
            end
        end

        for (int unsigned k = 0; k < 32; k++) begin
            yr[8'(8 * k) +: 8] = sr[5][5'(k)][7:0];
            yi[8'(8 * k) +: 8] = si[5][5'(k)][7:0];
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            xr_q         <= '0;
            xi_q         <= '0;
            Xk_vect_real <= '0;
            Xk_vect_imag <= '0;
        end else begin
            xr_q         <= Xn_vect_real;
            xi_q         <= Xn_vect_imag;
            Xk_vect_real <= yr;
            Xk_vect_imag <= yi;
        end
    end

endmodule

// File: tb/tb_fft32.sv
// Directed and streaming checks for fft32, including async reset behaviour.
module tb_fft32;

    logic         clk1;
    logic         rst;
    logic [255:0] xr;
    logic [255:0] xi;
    logic [255:0] yr;
    logic [255:0] yi;

    int tests = 0;
    int fails = 0;
    int tc [16];
    int ts [16];

    fft32 dut (
        .clk1         (clk1),
        .rst          (rst),
        .Xn_vect_real (xr),
        .Xn_vect_imag (xi),
        .Xk_vect_real (yr),
        .Xk_vect_imag (yi)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    function automatic int w16(input int x);
        logic signed [15:0] t;
        t = x[15:0];
        return int'(t);
    endfunction

    // Independent bit-accurate reference of the DIT transform.
    task automatic model(input logic [255:0] in_r, input logic [255:0] in_i,
                         output logic [255:0] out_r, output logic [255:0] out_i);
        int ar [32];
        int ai [32];
        logic signed [7:0] b;
        int r, u, v, m, p_r, p_i, t_r, t_i, a_r, a_i;
        for (int n = 0; n < 32; n++) begin
            r = 0;
            for (int q = 0; q < 5; q++)
                if (((n >> q) & 1) == 1) r = r | (1 << (4 - q));
            b = in_r[8*n +: 8];
            ar[r] = b;
            b = in_i[8*n +: 8];
            ai[r] = b;
        end
        for (int len = 2; len <= 32; len = len * 2) begin
            for (int i = 0; i < 32; i = i + len) begin
                for (int j = 0; j < len / 2; j++) begin
                    m   = j * (32 / len);
                    u   = i + j;
                    v   = u + len / 2;
                    p_r = ar[v] * tc[m] - ai[v] * ts[m];
                    p_i = ar[v] * ts[m] + ai[v] * tc[m];
                    t_r = w16((p_r + 128) >>> 8);
                    t_i = w16((p_i + 128) >>> 8);
                    a_r = ar[u];
                    a_i = ai[u];
                    ar[u] = w16(a_r + t_r);
                    ai[u] = w16(a_i + t_i);
                    ar[v] = w16(a_r - t_r);
                    ai[v] = w16(a_i - t_i);
                end
            end
        end
        for (int k = 0; k < 32; k++) begin
            out_r[8*k +: 8] = ar[k][7:0];
            out_i[8*k +: 8] = ai[k][7:0];
        end
    endtask

    task automatic directed(input string tag, input logic [255:0] vr, input logic [255:0] vi,
                            input logic [255:0] er, input logic [255:0] ei);
        xr = vr;
        xi = vi;
        step();
        step();
        chk({tag, "_re"}, yr, er);
        chk({tag, "_im"}, yi, ei);
    endtask

    logic [255:0] str_r [10];
    logic [255:0] str_i [10];
    logic [255:0] exp_r [10];
    logic [255:0] exp_i [10];
    logic [255:0] e8_r, e8_i, mr, mi, va_r, va_i, vb_r, vb_i;
    logic [7:0]   byt;

    initial begin
        for (int q = 0; q < 16; q++) begin
            tc[q] = int'($floor( 256.0 * $cos(2.0 * 3.14159265358979 * q / 32.0) + 0.5));
            ts[q] = int'($floor(-256.0 * $sin(2.0 * 3.14159265358979 * q / 32.0) + 0.5));
        end

        rst = 1'b0;
        xr  = 256'h01;
        xi  = '0;
        #2;
        chk("reset_re", yr, '0);
        chk("reset_im", yi, '0);
        step();
        step();
        chk("in_reset_re", yr, '0);
        chk("in_reset_im", yi, '0);

        @(negedge clk1);
        rst = 1'b1;
        step();
        chk("release_e1_re", yr, '0);
        chk("release_e1_im", yi, '0);
        step();
        chk("impulse_re", yr, {32{8'h01}});
        chk("impulse_im", yi, '0);
        step();
        chk("hold_re", yr, {32{8'h01}});
        chk("hold_im", yi, '0);

        directed("dc",        {32{8'h01}},        '0,          256'h20,          '0);
        directed("alt",       {16{8'hFF, 8'h01}}, '0,          256'h20 << 128,   '0);
        directed("imag_imp",  '0,                 256'h01,     '0,               {32{8'h01}});
        directed("both_imp",  256'h01,            256'h01,     {32{8'h01}},      {32{8'h01}});
        directed("wrap_7f",   {32{8'h7F}},        '0,          256'hE0,          '0);

        // x[8]=1 gives X[k] = (-j)^k exactly.
        for (int k = 0; k < 32; k++) begin
            case (k % 4)
                0:       begin e8_r[8*k +: 8] = 8'h01; e8_i[8*k +: 8] = 8'h00; end
                1:       begin e8_r[8*k +: 8] = 8'h00; e8_i[8*k +: 8] = 8'hFF; end
                2:       begin e8_r[8*k +: 8] = 8'hFF; e8_i[8*k +: 8] = 8'h00; end
                default: begin e8_r[8*k +: 8] = 8'h00; e8_i[8*k +: 8] = 8'h01; end
            endcase
        end
        directed("minus_j",   256'h01 << 64,      '0,          e8_r,             e8_i);

        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < 32; k++) begin
                case ($urandom_range(0, 2))
                    0:       byt = 8'h00;
                    1:       byt = 8'h01;
                    default: byt = 8'hFF;
                endcase
                str_r[v][8*k +: 8] = byt;
                case ($urandom_range(0, 2))
                    0:       byt = 8'h00;
                    1:       byt = 8'h01;
                    default: byt = 8'hFF;
                endcase
                str_i[v][8*k +: 8] = byt;
            end
            model(str_r[v], str_i[v], exp_r[v], exp_i[v]);
        end
        for (int c = 0; c <= 10; c++) begin
            if (c < 10) begin
                xr = str_r[c];
                xi = str_i[c];
            end
            step();
            if (c >= 1) begin
                chk($sformatf("stream%0d_re", c - 1), yr, exp_r[c - 1]);
                chk($sformatf("stream%0d_im", c - 1), yi, exp_i[c - 1]);
            end
        end

        va_r = {32{8'h01}};
        va_i = {16{8'hFF, 8'h01}};
        vb_r = {8{8'h01, 8'hFF, 8'h00, 8'h01}};
        vb_i = {32{8'hFF}};
        xr = va_r;
        xi = va_i;
        step();
        xr = vb_r;
        xi = vb_i;
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_async_re", yr, '0);
        chk("mid_rst_async_im", yi, '0);
        step();
        chk("mid_rst_edge_re", yr, '0);
        chk("mid_rst_edge_im", yi, '0);
        @(negedge clk1);
        rst = 1'b1;
        step();
        chk("mid_rel_e1_re", yr, '0);
        chk("mid_rel_e1_im", yi, '0);
        step();
        model(vb_r, vb_i, mr, mi);
        chk("mid_rel_e2_re", yr, mr);
        chk("mid_rel_e2_im", yi, mi);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
